// File: rtl/vga_pattern_sequencer.sv
// Frame-synchronous VGA test-pattern controller: debounced buttons, end-of-frame commit, 6-bit RGB.
// Optional indicator overlay enabled by defining PATTERN_OSD_EN.
`timescale 1ns/1ps
module vga_pattern_sequencer #(
   parameter int unsigned H_PIXELS        = 640,
   parameter int unsigned V_PIXELS        = 480,
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned AUTO_FRAMES     = 120
) (
   input  logic       pix_clk,
   input  logic       reset,
   input  logic [3:0] buttons,
   input  logic [9:0] h_sel,
   input  logic [8:0] v_sel,
   input  logic       display_en,
   output logic [1:0] red,
   output logic [1:0] grn,
   output logic [1:0] blu,
   output logic [1:0] pattern,
   output logic       auto_mode
);

   localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned FcW = $clog2(AUTO_FRAMES + 1);

   logic [3:0]     sync1_q, sync2_q, db_q, db_d, db_prev_q, press;
   logic [DbW-1:0] cnt_q [4];
   logic [DbW-1:0] cnt_d [4];

   logic [1:0]     pend_pat_q, pend_pat_d, base_pat, pattern_q, pattern_d;
   logic           pend_auto_q, pend_auto_d, pend_inv_q, pend_inv_d;
   logic           auto_mode_q, auto_mode_d, invert_q, invert_d;
   logic [FcW-1:0] frame_cnt_q, frame_cnt_d;
   logic           bnd, adv;
   logic [5:0]     rgb_q, rgb_d;

   // Debounce: flip only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         db_d[i]  = db_q[i];
         cnt_d[i] = '0;
         if (sync2_q[i] != db_q[i]) begin
            if (cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) db_d[i] = sync2_q[i];
            else cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   assign press = db_q & ~db_prev_q;
   assign bnd   = display_en && (h_sel == 10'(H_PIXELS - 1)) && (v_sel == 9'(V_PIXELS - 1));
   assign adv   = auto_mode_q && (frame_cnt_q == FcW'(AUTO_FRAMES - 1));

   always_comb begin
      base_pat    = bnd ? pend_pat_q + {1'b0, adv} : pend_pat_q;
      pend_pat_d  = base_pat;
      if (press[0] && !press[1]) pend_pat_d = base_pat + 2'd1;
      else if (press[1] && !press[0]) pend_pat_d = base_pat - 2'd1;
      pend_auto_d = pend_auto_q ^ press[2];
      pend_inv_d  = pend_inv_q ^ press[3];
      pattern_d   = pattern_q;
      auto_mode_d = auto_mode_q;
      invert_d    = invert_q;
      frame_cnt_d = frame_cnt_q;
      if (bnd) begin
         pattern_d   = pend_pat_q + {1'b0, adv};
         auto_mode_d = pend_auto_q;
         invert_d    = pend_inv_q;
      end
      // Counter only runs while auto mode is committed, so it starts from 0 on enable.
      if (!auto_mode_q) frame_cnt_d = '0;
      else if (bnd) frame_cnt_d = adv ? '0 : frame_cnt_q + 1'b1;
   end

   always_comb begin
      rgb_d = '0;
      unique case (pattern_q)
         2'd0: rgb_d = {{2{h_sel[9]}}, {2{h_sel[8]}}, {2{h_sel[7]}}};
         2'd1: rgb_d = (h_sel > {1'b0, v_sel}) ? 6'b110000 : 6'b000011;
         2'd2: rgb_d = (h_sel[5] ^ v_sel[5]) ? 6'b111111 : 6'b000000;
         2'd3: rgb_d = {h_sel[9:8], v_sel[8:7], h_sel[9:8] ^ v_sel[8:7]};
         default: rgb_d = '0;
      endcase
      if (invert_q) rgb_d = rgb_d ^ 6'b111111;
`ifdef PATTERN_OSD_EN
      // Overlay sits above the inversion so the indicator keeps fixed colours.
      if ((v_sel < 9'd8) && (h_sel < 10'd32)) begin
         rgb_d = (h_sel[4:3] == pattern_q) ? 6'b111111 : 6'b000000;
         if (auto_mode_q && (h_sel == 10'd31) && (v_sel == 9'd7)) rgb_d = 6'b110000;
      end
`endif
      if (!display_en) rgb_d = '0;
   end

   always_ff @(posedge pix_clk or negedge reset) begin
      if (!reset) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         db_q        <= '0;
         db_prev_q   <= '0;
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
         pend_pat_q  <= '0;
         pend_auto_q <= 1'b0;
         pend_inv_q  <= 1'b0;
         pattern_q   <= '0;
         auto_mode_q <= 1'b0;
         invert_q    <= 1'b0;
         frame_cnt_q <= '0;
         rgb_q       <= '0;
      end else begin
         sync1_q     <= buttons;
         sync2_q     <= sync1_q;
         db_q        <= db_d;
         db_prev_q   <= db_q;
         for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
         pend_pat_q  <= pend_pat_d;
         pend_auto_q <= pend_auto_d;
         pend_inv_q  <= pend_inv_d;
         pattern_q   <= pattern_d;
         auto_mode_q <= auto_mode_d;
         invert_q    <= invert_d;
         frame_cnt_q <= frame_cnt_d;
         rgb_q       <= rgb_d;
      end
   end

   assign red       = rgb_q[5:4];
   assign grn       = rgb_q[3:2];
   assign blu       = rgb_q[1:0];
   assign pattern   = pattern_q;
   assign auto_mode = auto_mode_q;

endmodule

// File: doc/vga_pattern_sequencer.md
Name: vga_pattern_sequencer

Overview:
- Frame-synchronous test-pattern controller between the VGA timing generator and the 6-bit RGB pins.
- Consumes h_sel/v_sel/display_en, takes four board buttons and selects one of four patterns.
- Commits every configuration change only at the end-of-frame boundary and drives registered RGB.
- Optional auto-cycle mode steps through the patterns every AUTO_FRAMES frames.

Parameters:
H_PIXELS, 640, visible pixels per line; boundary detect uses H_PIXELS-1
V_PIXELS, 480, visible lines per frame; boundary detect uses V_PIXELS-1
DEBOUNCE_CYCLES, 250000, consecutive stable pix_clk cycles before a debounced button changes (10 ms at 25 MHz)
AUTO_FRAMES, 120, frames per step in auto-cycle mode (>=1)

Ports:
pix_clk  in  1  pixel clock, sole clock
reset  in  1  asynchronous, active-low reset
buttons  in  4  raw async buttons, active-high: [0] next, [1] prev, [2] toggle auto, [3] toggle invert
h_sel  in  10  current pixel column from timing generator
v_sel  in  9  current pixel line
display_en  in  1  high during visible region
red  out  2  red level
grn  out  2  green level
blu  out  2  blue level
pattern  out  2  committed pattern index
auto_mode  out  1  committed auto-cycle flag

Behaviour:
- Reset (reset=0, async): red/grn/blu=0, pattern=0, auto_mode=0; pending pattern, invert, frame counter, synchronisers and debounced states all 0.
- Input conditioning, per button:
  - 2-flop synchroniser, then debounce counter.
  - The debounced state takes the synchronised value after DEBOUNCE_CYCLES consecutive cycles of disagreement; any agreement clears the counter.
  - press = single-cycle pulse on debounced 0->1; release generates nothing.
- Pending registers: pend_pat(2), pend_auto, pend_inv.
  - next: pend_pat+1, wraps 3->0.
  - prev: pend_pat-1, wraps 0->3.
  - next and prev in the same cycle: no change.
  - toggle auto: inverts pend_auto.
  - toggle invert: inverts pend_inv.
- Frame boundary (bnd) = display_en & h_sel==H_PIXELS-1 & v_sel==V_PIXELS-1.
- At bnd:
  - committed pattern <= pend_pat+adv; auto_mode <= pend_auto; invert <= pend_inv.
  - adv=1 when committed auto_mode=1 and frame_cnt==AUTO_FRAMES-1; frame_cnt then clears, otherwise increments.
  - pend_pat is also updated to pend_pat+adv.
  - A press in the bnd cycle applies after the commit: pend_pat(new) = pend_pat+adv±1. The press is not visible until the following boundary.
- frame_cnt clears when committed auto_mode goes 0->1, and holds at 0 while auto_mode=0.
- Pixel path, latency 1: RGB registered from the same-cycle h_sel/v_sel/display_en; new settings apply from the first pixel after bnd.
  - display_en=0: RGB=000000.
  - Pattern 0, bars: idx=h_sel[9:7]; red={2{idx[2]}}, grn={2{idx[1]}}, blu={2{idx[0]}}.
  - Pattern 1, diagonal: h_sel>v_sel (v_sel zero-extended to 10 bits) -> red=11, else blu=11; other channels 00.
  - Pattern 2, checker: h_sel[5]^v_sel[5] -> 111111, else 000000.
  - Pattern 3, gradient: red=h_sel[9:8], grn=v_sel[8:7], blu=h_sel[9:8]^v_sel[8:7].
  - invert=1: visible RGB XOR 111111.
- Reset mid-frame forces the reset values immediately. After release, the first bnd commits the defaults; no partial commit.
- The block never stalls on timing-input glitches; it tolerates h_sel/v_sel values beyond H/V_PIXELS.

Optional Feature:
- Macro: PATTERN_OSD_EN.
- Defined: indicator overlay over the pattern output.
  - Region: v_sel<8, h_sel<32; four 8-px cells, cell i = h_sel[4:3].
  - Cell i = 111111 if i==pattern, else 000000.
  - Bit 7 pixel (h_sel=31, v_sel=7) = 110000 when auto_mode=1.
  - Overlay is not inverted; latency unchanged.
- Undefined: no overlay logic; output is pattern output only.

Test Plan:
- Bench setup: DEBOUNCE_CYCLES=4, AUTO_FRAMES=3, H_PIXELS=64, V_PIXELS=32; timing stimulus generated by the bench.
- Bounce filter: buttons[0] high 3 cycles -> pend_pat stays 0. Held 10 cycles -> pattern stays 0 until bnd, then pattern=1 from the next frame's first pixel.
- Wrap: from pattern 0, one prev press -> pattern=3 after next bnd. Then next twice -> pattern=1.
- Diagonal pixels: pattern 1, h_sel=5, v_sel=3, display_en=1 -> next cycle RGB red=11 grn=00 blu=00. h_sel=2 -> blu=11. display_en=0 -> 000000. invert=1 with h_sel=5, v_sel=3 -> red=00 grn=11 blu=11.
- Auto cycle: toggle auto, then run 12 frames -> pattern sequence 0,0,0,1,1,1,2,2,2,3,3,3, then wraps to 0.
- Press on boundary: next press lands exactly on the bnd cycle while pend_pat=2 -> that frame commits 2, the following frame commits 3.
- Async reset: reset low mid-line with pattern=3, invert=1 -> RGB=000000, pattern=0, auto_mode=0 before the next pix_clk edge; after release, bars pattern appears.
